// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types and constants for the unified-memory arbiter.
//   addr_t / data_t : memory word address and data types
//   enable_t        : single-bit strobe type
//   be_t            : byte-enable vector (MEM_BE_W_DEFAULT bits)
//   arb_owner_e     : owner of the read response due in the next cycle
package mem_arbiter_pkg;

    localparam int ADDR_W               = 32;
    localparam int DATA_W               = 32;
    localparam int MEM_BE_W_DEFAULT     = DATA_W / 8;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef logic [ADDR_W-1:0]           addr_t;
    typedef logic [DATA_W-1:0]           data_t;
    typedef logic                        enable_t;
    typedef logic [MEM_BE_W_DEFAULT-1:0] be_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// port (imem) and the load/store port (dmem). One access is granted per
// cycle; dmem normally wins, but a fetch that has been refused STARVE_LIMIT
// consecutive cycles wins the next arbitration. Read data returns one cycle
// after the grant with an rvalid strobe on the owning port.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req_i/addr_i        fetch request (held until granted)
//   imem_gnt_o               fetch accepted this cycle
//   imem_rvalid_o/rdata_o    fetch data, cycle after grant
//   dmem_req_i/we_i/addr_i/be_i/wdata_i  load/store request (held until granted)
//   dmem_gnt_o               load/store accepted this cycle
//   dmem_rvalid_o/rdata_o    load data, cycle after a load grant
//   mem_en_o/we_o/be_o/addr_o/wdata_o    memory command, driven in the grant cycle
//   mem_rdata_i              memory read data, one cycle after a read command
//
// Build option: define MEM_ARB_STATS_EN to add conflict_cnt_o and
// imem_stall_cnt_o (32-bit wrapping event counters).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int MEM_BE_W     = MEM_BE_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                imem_req_i,
    input  addr_t               imem_addr_i,
    output logic                imem_gnt_o,
    output logic                imem_rvalid_o,
    output data_t               imem_rdata_o,
    input  logic                dmem_req_i,
    input  logic                dmem_we_i,
    input  addr_t               dmem_addr_i,
    input  logic [MEM_BE_W-1:0] dmem_be_i,
    input  data_t               dmem_wdata_i,
    output logic                dmem_gnt_o,
    output logic                dmem_rvalid_o,
    output data_t               dmem_rdata_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [MEM_BE_W-1:0] mem_be_o,
    output addr_t               mem_addr_o,
    output data_t               mem_wdata_o,
    input  data_t               mem_rdata_i
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]         conflict_cnt_o,
    output logic [31:0]         imem_stall_cnt_o
`endif
);

    localparam int                WCNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(STARVE_LIMIT);

    enable_t           imem_gnt_s;
    enable_t           dmem_gnt_s;
    logic [WCNT_W-1:0] wait_cnt_r;
    logic [WCNT_W-1:0] wait_cnt_s;
    arb_owner_e        owner_r;
    arb_owner_e        owner_s;

    // Arbitration: dmem first unless the fetch has waited long enough.
    // Grants are suppressed while reset is asserted so all outputs read idle.
    always_comb begin
        imem_gnt_s = 1'b0;
        dmem_gnt_s = 1'b0;
        if (rst) begin
            imem_gnt_s = 1'b0;
            dmem_gnt_s = 1'b0;
        end else if (imem_req_i && (!dmem_req_i || (wait_cnt_r == WAIT_MAX))) begin
            imem_gnt_s = 1'b1;
        end else if (dmem_req_i) begin
            dmem_gnt_s = 1'b1;
        end else begin
            imem_gnt_s = 1'b0;
            dmem_gnt_s = 1'b0;
        end
    end

    // Next value of the fetch wait counter: count refusals, saturate, clear otherwise.
    always_comb begin
        wait_cnt_s = {WCNT_W{1'b0}};
        if (imem_req_i && !imem_gnt_s) begin
            if (wait_cnt_r == WAIT_MAX) begin
                wait_cnt_s = wait_cnt_r;
            end else begin
                wait_cnt_s = wait_cnt_r + WCNT_W'(1);
            end
        end else begin
            wait_cnt_s = {WCNT_W{1'b0}};
        end
    end

    // Next response owner: only read grants produce a response.
    always_comb begin
        owner_s = NONE;
        if (imem_gnt_s) begin
            owner_s = RESP_I;
        end else if (dmem_gnt_s && !dmem_we_i) begin
            owner_s = RESP_D;
        end else begin
            owner_s = NONE;
        end
    end

    // State registers: wait counter and response owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= {WCNT_W{1'b0}};
            owner_r    <= NONE;
        end else begin
            wait_cnt_r <= wait_cnt_s;
            owner_r    <= owner_s;
        end
    end

    // Memory command mux: the granted port drives the macro in the grant cycle.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = {MEM_BE_W{1'b0}};
        mem_addr_o  = {ADDR_W{1'b0}};
        mem_wdata_o = {DATA_W{1'b0}};
        if (imem_gnt_s) begin
            mem_we_o    = 1'b0;
            mem_be_o    = {MEM_BE_W{1'b1}};
            mem_addr_o  = imem_addr_i;
            mem_wdata_o = {DATA_W{1'b0}};
        end else if (dmem_gnt_s) begin
            mem_we_o    = dmem_we_i;
            mem_be_o    = dmem_be_i;
            mem_addr_o  = dmem_addr_i;
            mem_wdata_o = dmem_wdata_i;
        end else begin
            mem_we_o    = 1'b0;
            mem_be_o    = {MEM_BE_W{1'b0}};
            mem_addr_o  = {ADDR_W{1'b0}};
            mem_wdata_o = {DATA_W{1'b0}};
        end
    end

    // Response steering: read data reaches only the owning port, zero elsewhere.
    always_comb begin
        imem_rvalid_o = 1'b0;
        dmem_rvalid_o = 1'b0;
        imem_rdata_o  = {DATA_W{1'b0}};
        dmem_rdata_o  = {DATA_W{1'b0}};
        case (owner_r)
            RESP_I: begin
                imem_rvalid_o = 1'b1;
                imem_rdata_o  = mem_rdata_i;
            end
            RESP_D: begin
                dmem_rvalid_o = 1'b1;
                dmem_rdata_o  = mem_rdata_i;
            end
            NONE: begin
                imem_rvalid_o = 1'b0;
                dmem_rvalid_o = 1'b0;
            end
            default: begin
                imem_rvalid_o = 1'b0;
                dmem_rvalid_o = 1'b0;
            end
        endcase
    end

    assign imem_gnt_o = imem_gnt_s;
    assign dmem_gnt_o = dmem_gnt_s;
    assign mem_en_o   = imem_gnt_s | dmem_gnt_s;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] conflict_cnt_r;
    logic [31:0] imem_stall_cnt_r;

    // Event counters: simultaneous requests and refused fetch cycles (wrapping).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_r   <= 32'd0;
            imem_stall_cnt_r <= 32'd0;
        end else begin
            if (imem_req_i && dmem_req_i) begin
                conflict_cnt_r <= conflict_cnt_r + 32'd1;
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
            if (imem_req_i && !imem_gnt_s) begin
                imem_stall_cnt_r <= imem_stall_cnt_r + 32'd1;
            end else begin
                imem_stall_cnt_r <= imem_stall_cnt_r;
            end
        end
    end

    assign conflict_cnt_o   = conflict_cnt_r;
    assign imem_stall_cnt_o = imem_stall_cnt_r;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural single-port memory.
// Stimulus pushes expected grant/command entries and expected read data into
// queues; a negedge monitor pops and compares against what the DUT presents.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_i;
    addr_t       imem_addr_i;
    logic        imem_gnt_o;
    logic        imem_rvalid_o;
    data_t       imem_rdata_o;
    logic        dmem_req_i;
    logic        dmem_we_i;
    addr_t       dmem_addr_i;
    logic [3:0]  dmem_be_i;
    data_t       dmem_wdata_i;
    logic        dmem_gnt_o;
    logic        dmem_rvalid_o;
    data_t       dmem_rdata_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    addr_t       mem_addr_o;
    data_t       mem_wdata_o;
    data_t       mem_rdata_i;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] conflict_cnt_o;
    logic [31:0] imem_stall_cnt_o;
`endif

    mem_arbiter #(.STARVE_LIMIT(4), .MEM_BE_W(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_gnt_o(imem_gnt_o),
        .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o),
        .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_addr_i(dmem_addr_i),
        .dmem_be_i(dmem_be_i), .dmem_wdata_i(dmem_wdata_i), .dmem_gnt_o(dmem_gnt_o),
        .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
`ifdef MEM_ARB_STATS_EN
        , .conflict_cnt_o(conflict_cnt_o), .imem_stall_cnt_o(imem_stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural memory: word i initialised to 0x1000_0000 + i.
    logic [31:0] mem [0:255];
    logic [31:0] rd_r = 32'd0;
    logic [7:0]  widx;
    assign widx        = mem_addr_o[9:2];
    assign mem_rdata_i = rd_r;

    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_o[b]) mem[widx][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end else begin
                rd_r <= mem[widx];
            end
        end
    end

    typedef struct {
        logic        eig;
        logic        edg;
        logic        ersp;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gexp_t;

    gexp_t       gq [$];
    logic [31:0] iq [$];
    logic [31:0] dq [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle plus its expected grant / response.
    task automatic drive(input logic ireq, input logic [31:0] iaddr,
                         input logic dreq, input logic dwe, input logic [31:0] daddr,
                         input logic [3:0] dbe, input logic [31:0] dwd,
                         input logic eig, input logic edg,
                         input logic ersp, input logic [31:0] edata);
        gexp_t g;
        @(posedge clk);
        #1;
        imem_req_i   = ireq;
        imem_addr_i  = iaddr;
        dmem_req_i   = dreq;
        dmem_we_i    = dwe;
        dmem_addr_i  = daddr;
        dmem_be_i    = dbe;
        dmem_wdata_i = dwd;
        g.eig   = eig;
        g.edg   = edg;
        g.ersp  = ersp;
        g.we    = edg ? dwe : 1'b0;
        g.be    = eig ? 4'hF : (edg ? dbe : 4'h0);
        g.addr  = eig ? iaddr : (edg ? daddr : 32'd0);
        g.wdata = (edg && dwe) ? dwd : 32'd0;
        gq.push_back(g);
        if (ersp && eig) iq.push_back(edata);
        if (ersp && edg) dq.push_back(edata);
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_gnt"},    {31'd0, imem_gnt_o},    32'd0);
        check({tag, "_dmem_gnt"},    {31'd0, dmem_gnt_o},    32'd0);
        check({tag, "_imem_rvalid"}, {31'd0, imem_rvalid_o}, 32'd0);
        check({tag, "_dmem_rvalid"}, {31'd0, dmem_rvalid_o}, 32'd0);
        check({tag, "_mem_en"},      {31'd0, mem_en_o},      32'd0);
        check({tag, "_mem_we"},      {31'd0, mem_we_o},      32'd0);
        check({tag, "_mem_be"},      {28'd0, mem_be_o},      32'd0);
        check({tag, "_imem_rdata"},  imem_rdata_o,           32'd0);
        check({tag, "_dmem_rdata"},  dmem_rdata_o,           32'd0);
`ifdef MEM_ARB_STATS_EN
        check({tag, "_conflict_cnt"}, conflict_cnt_o,   32'd0);
        check({tag, "_stall_cnt"},    imem_stall_cnt_o, 32'd0);
`endif
    endtask

    // Monitor: grant/command per cycle, rvalid exactly one cycle after a read grant.
    logic i_exp = 1'b0;
    logic d_exp = 1'b0;
    logic ipend = 1'b0;
    logic dpend = 1'b0;

    always @(negedge clk) begin : monitor
        gexp_t       g;
        logic [31:0] exp_d;
        if (rst) begin
            i_exp <= 1'b0;
            d_exp <= 1'b0;
            ipend <= 1'b0;
            dpend <= 1'b0;
        end else begin
            check("imem_rvalid", {31'd0, imem_rvalid_o}, {31'd0, i_exp});
            check("dmem_rvalid", {31'd0, dmem_rvalid_o}, {31'd0, d_exp});
            if (imem_rvalid_o && iq.size() > 0) begin
                exp_d = iq.pop_front();
                check("imem_rdata", imem_rdata_o, exp_d);
            end else if (!imem_rvalid_o) begin
                check("imem_rdata_idle", imem_rdata_o, 32'd0);
            end
            if (dmem_rvalid_o && dq.size() > 0) begin
                exp_d = dq.pop_front();
                check("dmem_rdata", dmem_rdata_o, exp_d);
            end else if (!dmem_rvalid_o) begin
                check("dmem_rdata_idle", dmem_rdata_o, 32'd0);
            end
            if (ipend) check("imem_req_held", {31'd0, imem_req_i}, 32'd1);
            if (dpend) check("dmem_req_held", {31'd0, dmem_req_i}, 32'd1);
            ipend <= imem_req_i && !imem_gnt_o;
            dpend <= dmem_req_i && !dmem_gnt_o;
            if (gq.size() > 0) begin
                g = gq.pop_front();
                check("imem_gnt", {31'd0, imem_gnt_o}, {31'd0, g.eig});
                check("dmem_gnt", {31'd0, dmem_gnt_o}, {31'd0, g.edg});
                check("mem_en",   {31'd0, mem_en_o},   {31'd0, g.eig | g.edg});
                if (g.eig || g.edg) begin
                    check("mem_addr", mem_addr_o, g.addr);
                    check("mem_we",   {31'd0, mem_we_o}, {31'd0, g.we});
                    check("mem_be",   {28'd0, mem_be_o}, {28'd0, g.be});
                    if (g.we) check("mem_wdata", mem_wdata_o, g.wdata);
                end
                i_exp <= g.eig && g.ersp;
                d_exp <= g.edg && g.ersp;
            end else begin
                i_exp <= 1'b0;
                d_exp <= 1'b0;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] c0;
    logic [31:0] s0;
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        rst = 1'b1;
        imem_req_i = 1'b0; imem_addr_i = 32'd0;
        dmem_req_i = 1'b0; dmem_we_i = 1'b0; dmem_addr_i = 32'd0;
        dmem_be_i = 4'h0; dmem_wdata_i = 32'd0;

        // Reset state, including requests asserted while in reset.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_idle");
        imem_req_i = 1'b1; dmem_req_i = 1'b1; dmem_addr_i = 32'h20;
        #1;
        check_reset_outputs("rst_req");
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_req_i = 1'b0; dmem_req_i = 1'b0;

        // Fetch only, back to back: 0x0 then 0x4.
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1000_0000);
        drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1000_0001);
        idle();
        idle();

        // Conflict: dmem load 0x20 first, then fetch 0x10.
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1000_0008);
        drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1000_0004);
        idle();

        // Store then load same address (read-after-write), plus a partial store.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h44, 4'h3, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 32'h1000_F00D);
        idle();

        // Starvation: both held 10 cycles; fetch wins cycles 5 and 10.
        for (int c = 1; c <= 10; c++) begin
            if (c == 5 || c == 10)
                drive(1'b1, 32'h8, 1'b1, 1'b0, 32'hC, 4'hF, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1000_0002);
            else
                drive(1'b1, 32'h8, 1'b1, 1'b0, 32'hC, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1000_0003);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hC, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1000_0003);
        idle();

        // Reset in the cycle after a load grant: response dropped.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dmem_req_i = 1'b1; imem_req_i = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        imem_req_i = 1'b0; dmem_req_i = 1'b0;
        #1;
        check("rst_release_dmem_rvalid", {31'd0, dmem_rvalid_o}, 32'd0);
        idle();
        idle();

        // Three conflict cycles, then fetch alone.
`ifdef MEM_ARB_STATS_EN
        c0 = conflict_cnt_o;
        s0 = imem_stall_cnt_o;
`endif
        for (int c = 0; c < 3; c++)
            drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1000_0001);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1000_0000);
`ifdef MEM_ARB_STATS_EN
        check("conflict_cnt_delta", conflict_cnt_o - c0,   32'd3);
        check("stall_cnt_delta",    imem_stall_cnt_o - s0, 32'd3);
`endif
        idle();
        idle();
        @(posedge clk);
        #1;
        check("gnt_queue_empty", gq.size(), 32'd0);
        check("imem_rsp_queue_empty", iq.size(), 32'd0);
        check("dmem_rsp_queue_empty", dq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous unified memory between the instruction-fetch requester and the load/store requester.
- Uses a req/gnt handshake per requester and returns read data one cycle after grant (rvalid).
- Data port has fixed priority, with an anti-starvation override for fetch.
- Sits between the core's IF/MEM stages and the memory macro; replaces direct dual-port wiring.

Parameters:
- STARVE_LIMIT, 4: consecutive denied imem-request cycles after which imem wins the next arbitration.
- MEM_BE_W, 4: byte-enable width (data_t width / 8).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- imem_req_i  in  1  fetch request; held with address until granted
- imem_addr_i  in  addr_t  fetch word address
- imem_gnt_o  out  1  request accepted this cycle
- imem_rvalid_o  out  1  imem_rdata_o valid (cycle after grant)
- imem_rdata_o  out  data_t  fetch data
- dmem_req_i  in  1  load/store request; held until granted
- dmem_we_i  in  1  1 = store, 0 = load
- dmem_addr_i  in  addr_t  data address, passed through unmodified
- dmem_be_i  in  MEM_BE_W  store byte enables
- dmem_wdata_i  in  data_t  store data
- dmem_gnt_o  out  1  request accepted this cycle
- dmem_rvalid_o  out  1  load data valid (cycle after load grant)
- dmem_rdata_o  out  data_t  load data
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write
- mem_be_o  out  MEM_BE_W  memory byte enables
- mem_addr_o  out  addr_t  memory address
- mem_wdata_o  out  data_t  memory write data
- mem_rdata_i  in  data_t  memory read data, valid one cycle after mem_en_o && !mem_we_o

Behaviour:
- Reset values (async, while rst=1):
  - All gnt, rvalid, mem_en_o, mem_we_o outputs = 0; mem_be_o = 0.
  - rdata outputs = 0.
  - Wait counter = 0; response owner = NONE.
- Grant logic is combinational from the requests and wait counter. At most one grant per cycle.
- Memory signals are driven in the grant cycle:
  - mem_en_o = imem_gnt_o | dmem_gnt_o.
  - Address, write, byte-enable and wdata come from the granted port. mem_be_o = 4'hF for fetch.
- Priority:
  - Default: dmem over imem.
  - If wait_cnt == STARVE_LIMIT and imem_req_i = 1, imem wins that cycle.
- wait_cnt:
  - Increments when imem_req_i && !imem_gnt_o, saturating at STARVE_LIMIT.
  - Clears on imem grant or when imem_req_i = 0.
  - Width $clog2(STARVE_LIMIT+1).
- Response FSM (registered owner of the outstanding read): states NONE, RESP_I, RESP_D.
  - Next state is RESP_I after an imem grant, RESP_D after a dmem load grant, else NONE.
  - A store grant leaves next = NONE; stores produce no rvalid.
  - In RESP_I: imem_rvalid_o = 1 and imem_rdata_o = mem_rdata_i.
  - In RESP_D: dmem_rvalid_o = 1 and dmem_rdata_o = mem_rdata_i.
  - rdata outputs = 0 when their port's rvalid is 0.
- Pipelining: a new grant is allowed in any state, including the response cycle, so back-to-back accesses sustain 1 access/cycle.
- Read-after-write: a load granted the cycle after a store to the same address returns the new data, because the memory writes at the grant edge.
- Reset mid-operation: the outstanding response is dropped, and no rvalid is issued in the first cycle after rst deasserts.
- Dropping a request before grant is illegal. The bench flags it; the arbiter does not hold state for it.
- No address alignment or range checking; that belongs to the memory.

Optional Feature:
- MEM_ARB_STATS_EN defined: adds ports conflict_cnt_o (32-bit) and imem_stall_cnt_o (32-bit).
  - conflict_cnt_o increments each cycle both requests are high.
  - imem_stall_cnt_o increments each cycle imem_req_i && !imem_gnt_o.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- defs package:
  - arb_owner_e enum (NONE, RESP_I, RESP_D).
  - STARVE_LIMIT default constant.
  - be_t typedef (MEM_BE_W bits).
  - Reuses the existing addr_t, data_t, enable_t.
- No sub-module; the FSM, counter and mux are in one module.

Test Plan:
- Imem only, addr 0x0 then 0x4 on consecutive cycles:
  - gnt each cycle; rvalid in cycles 2 and 3 with mem[0] and mem[1].
  - dmem_rvalid_o stays 0.
- Simultaneous imem 0x10 and dmem load 0x20:
  - dmem granted first, rvalid next cycle with mem[8].
  - imem granted the following cycle, data mem[4].
- Dmem store 0x40 data 0xDEADBEEF be 4'hF, then load 0x40:
  - Store gets no rvalid; load returns 0xDEADBEEF one cycle after its grant.
- Starvation, with dmem_req_i held high continuously for 10 cycles and imem_req_i high:
  - imem granted in cycle 5, i.e. after 4 denials.
  - wait_cnt then clears and dmem resumes winning.
- Reset asserted in the cycle after a load grant:
  - dmem_rvalid_o = 0 immediately, and stays 0 after release.
  - All outputs hold their reset values.
- With MEM_ARB_STATS_EN, 3 conflict cycles:
  - conflict_cnt_o = 3.
  - imem_stall_cnt_o = 3 (STARVE_LIMIT=4, so no override occurs in 3 cycles).
